// File: rtl/seg_disp_sched.sv
// seg_disp_sched: shares one 4-digit multiplexed 7-segment display between
// three BCD requesters. Round-robin grant with a guaranteed minimum hold
// (SHOW), level-held ownership (OWN) and time-slicing under contention.
// The owner's BCD value is decoded to active-low common-anode segment
// patterns (bit0=a .. bit6=g, bit7=dp, dp always off) one cycle behind gnt.
// Optional feature: define SEG_LZB_EN to compile in leading-zero blanking.
module seg_disp_sched #(
  parameter int CNT_1MS  = 24_000,
  parameter int HOLD_MS  = 500,
  parameter int SLICE_MS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] bcd0,
  input  logic [15:0] bcd1,
  input  logic [15:0] bcd2,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [7:0]  k_num,
  output logic [7:0]  h_num,
  output logic [7:0]  d_num,
  output logic [7:0]  u_num
);

  localparam int PRE_W = (CNT_1MS > 1) ? $clog2(CNT_1MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CNT_1MS - 1);
  localparam logic [15:0] HOLD_T  = 16'(HOLD_MS);
  localparam logic [15:0] SLICE_T = 16'(SLICE_MS);
  localparam logic [7:0]  SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       gnt_nx;
  logic [1:0]       last, last_nx;
  logic             start;
  logic [PRE_W-1:0] pre;
  logic [15:0]      t_ms, t_nx;
  logic             tick;
  logic [2:0]       cand;
  logic             owner_req;
  logic             other_req;

  logic [15:0]      bcd_sel;
  logic [7:0]       seg_k, seg_h, seg_d, seg_u;
  logic [7:0]       k_p1, h_p1, d_p1, u_p1;

  // Round-robin pick: first set request in order last+1, last+2, last.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [2:0] pick;
    pick = 3'b000;
    case (l)
      2'd0: begin
        if (r[1])      pick = 3'b010;
        else if (r[2]) pick = 3'b100;
        else if (r[0]) pick = 3'b001;
      end
      2'd1: begin
        if (r[2])      pick = 3'b100;
        else if (r[0]) pick = 3'b001;
        else if (r[1]) pick = 3'b010;
      end
      default: begin
        if (r[0])      pick = 3'b001;
        else if (r[1]) pick = 3'b010;
        else if (r[2]) pick = 3'b100;
      end
    endcase
    return pick;
  endfunction

  // One-hot grant to requester index.
  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Elapsed-ms counter sticks at its ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // BCD digit to active-low segments; non-decimal codes show a dash.
  function automatic logic [7:0] dec7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // t_nx is the elapsed-ms value that will hold after this edge; the
  // hold/slice thresholds are judged on it so SHOW lasts exactly
  // HOLD_MS*CNT_1MS cycles and a slice exactly SLICE_MS*CNT_1MS cycles.
  assign tick      = (pre == PRE_MAX);
  assign t_nx      = tick ? sat_inc(t_ms) : t_ms;
  assign cand      = rr_pick(req, last);
  assign owner_req = |(req & gnt);
  assign other_req = |(req & ~gnt);

  // Arbitration: next state, next grant and round-robin pointer.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nx   = cand;
          last_nx  = oh_idx(cand);
          state_nx = SHOW;
          start    = 1'b1;
        end
      end
      SHOW: begin
        if (t_nx >= HOLD_T) state_nx = OWN;
      end
      OWN: begin
        if (!owner_req) begin
          if (|req) begin
            gnt_nx   = cand;
            last_nx  = oh_idx(cand);
            state_nx = SHOW;
            start    = 1'b1;
          end else begin
            gnt_nx   = 3'b000;
            state_nx = IDLE;
          end
        end else if (other_req && (t_nx >= SLICE_T)) begin
          gnt_nx   = cand;
          last_nx  = oh_idx(cand);
          state_nx = SHOW;
          start    = 1'b1;
        end
      end
      default: begin
        gnt_nx   = 3'b000;
        state_nx = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, grant, pointer, ms prescaler and timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 3'b000;
      last  <= 2'd2;
      pre   <= '0;
      t_ms  <= 16'd0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      if (start) begin
        pre  <= '0;
        t_ms <= 16'd0;
      end else begin
        pre  <= tick ? '0 : pre + 1'b1;
        t_ms <= t_nx;
      end
    end
  end

  assign busy = |gnt;

  // Owner selection and per-digit decode (live bcd of the current owner).
  always_comb begin
    bcd_sel = 16'h0000;
    if (gnt[0])      bcd_sel = bcd0;
    else if (gnt[1]) bcd_sel = bcd1;
    else if (gnt[2]) bcd_sel = bcd2;
    seg_k = dec7(bcd_sel[15:12]);
    seg_h = dec7(bcd_sel[11:8]);
    seg_d = dec7(bcd_sel[7:4]);
    seg_u = dec7(bcd_sel[3:0]);
`ifdef SEG_LZB_EN
    if (bcd_sel[15:12] == 4'd0) seg_k = SEG_OFF;
    if (bcd_sel[15:8]  == 8'd0) seg_h = SEG_OFF;
    if (bcd_sel[15:4]  == 12'd0) seg_d = SEG_OFF;
`endif
  end

  // Segment output stage, one cycle behind gnt; blank when nobody owns.
  always_ff @(posedge clk) begin
    if (!rst_n || (gnt == 3'b000)) begin
      k_p1 <= SEG_OFF;
      h_p1 <= SEG_OFF;
      d_p1 <= SEG_OFF;
      u_p1 <= SEG_OFF;
    end else begin
      k_p1 <= seg_k;
      h_p1 <= seg_h;
      d_p1 <= seg_d;
      u_p1 <= seg_u;
    end
  end

  assign k_num = k_p1;
  assign h_num = h_p1;
  assign d_num = d_p1;
  assign u_num = u_p1;

endmodule
